pll_lock_sequencer: RTL and testbench
=====================================

# pll_lock_sequencer

Reset and lock sequencer for the core's three-output PLL (117.9648 MHz system clock, 13.1072 MHz video clock, and a phase-shifted 13.1072 MHz copy), running on the 74.25 MHz reference clock.
- Pulses the PLL reset, waits for a filtered lock, retries on timeout, and releases a single core reset.
- Each clock domain resynchronises that core reset locally.
- Watches for lock loss and restarts the sequence on loss or on a bridge-initiated relock request.

## Interface
Parameters:
- RST_PULSE_CYCLES, 16: cycles `pll_rst` is held high per attempt (≥1)
- LOCK_STABLE_CYCLES, 1024: consecutive synchronised-lock cycles required before release (≥1)
- LOCK_TIMEOUT_CYCLES, 1048576: cycles in WAIT_LOCK before the attempt is abandoned
- MAX_RETRIES, 7: failed attempts tolerated before FAIL (1..15)

Ports:
- clk_74a  in  1  74.25 MHz reference clock, also the PLL refclk
- reset_n  in  1  asynchronous active-low reset
- pll_locked  in  1  PLL lock, asynchronous to clk_74a
- relock_req  in  1  single-cycle pulse to restart the sequence from any state
- pll_rst  out  1  PLL reset, active high
- core_reset_n  out  1  core reset, active low, asserted whenever the PLL is not trusted
- ready  out  1  high only in RUN
- fail  out  1  high only in FAIL
- state  out  3  encoded current state
- retry_count  out  4  failed attempts in the current sequence
- lock_loss_count  out  16  saturating lock-loss events (see Configuration)

## Operation
- `pll_locked` passes through a 2-FF synchroniser to give `lock_s`.
- All logic below uses `lock_s`.

States:
- **RESET_PLL** (encoding 0)
  - `pll_rst` = 1; counter runs to RST_PULSE_CYCLES−1.
  - Then go to WAIT_LOCK with counter cleared.
- **WAIT_LOCK** (1)
  - `pll_rst` = 0.
  - Counter hits LOCK_TIMEOUT_CYCLES−1 without `lock_s`:
    - retry_count+1;
    - if the new value equals MAX_RETRIES, go to FAIL;
    - otherwise go to RESET_PLL.
  - `lock_s` = 1: go to STABLE with counter cleared.
- **STABLE** (2)
  - `lock_s` = 0: go to WAIT_LOCK (timeout counter restarts; retry_count unchanged).
  - LOCK_STABLE_CYCLES consecutive `lock_s` cycles: go to RUN.
- **RUN** (3)
  - `core_reset_n` = 1, ready = 1.
  - `lock_s` = 0: lock_loss_count+1, retry_count cleared, go to RESET_PLL.
- **FAIL** (4)
  - `pll_rst` = 1 and held.
  - Leaves only on `relock_req` or reset.

Rules that apply across states:
- `core_reset_n` = 0 in every state except RUN.
- `relock_req` in any state: go to RESET_PLL, clear the counter and retry_count.
  - `relock_req` has priority over every other transition in the same cycle.
  - Lock loss coincident with `relock_req` in RUN still increments lock_loss_count.
- Counters are wide enough for the largest parameter, sized with $clog2(max+1).
- lock_loss_count saturates at 16'hFFFF.

## Timing
- Reset values:
  - state = RESET_PLL, `pll_rst` = 1, `core_reset_n` = 0
  - ready = 0, fail = 0, retry_count = 0, lock_loss_count = 0
  - synchroniser flops = 0
- All outputs are registered. `core_reset_n` and `pll_rst` change in the same cycle as state, with no combinational path from inputs.
- `pll_rst` high time per attempt is exactly RST_PULSE_CYCLES cycles.
- Release latency: from a `pll_locked` rise that then stays high, `core_reset_n` rises after 2 (synchroniser) + LOCK_STABLE_CYCLES + 1 cycles.
- Loss latency: from a `pll_locked` fall in RUN, `core_reset_n` falls 3 cycles later (2 synchroniser + 1 register).
- Timeout: exactly LOCK_TIMEOUT_CYCLES cycles spent in WAIT_LOCK.
- Reset assertion mid-operation: immediately forces the reset values listed above.

## Configuration
PLL_SEQ_LOSS_COUNTER_EN:
- Defined: lock_loss_count behaves as specified.
- Undefined:
  - the counter register is removed;
  - the `lock_loss_count` port remains and is tied to 16'd0;
  - sequencing is unchanged.

## Structure
- Package `pll_seq_pkg`:
  - state enum `pll_seq_state_t` (RESET_PLL=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4);
  - the state width constant (3);
  - the lock_loss_count width constant (16).
- Sub-module `sync_2ff`: single-bit two-flop synchroniser with async active-low reset, instantiated for `pll_locked`.

## Test plan
Bench parameters: RST_PULSE_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=64, MAX_RETRIES=2.
- Nominal lock: deassert reset; raise `pll_locked` 10 cycles after `pll_rst` falls.
  - `pll_rst` high exactly 4 cycles; `core_reset_n` rises 11 cycles after the `pll_locked` rise; ready = 1.
- Glitchy lock: `pll_locked` high 5 cycles, low 1, then high.
  - Stable count restarts; release occurs 11 cycles after the final rise; retry_count = 0.
- Timeout then success: first attempt gets no lock.
  - After 64 WAIT_LOCK cycles retry_count = 1 and `pll_rst` pulses 4 cycles.
  - Lock on the second attempt reaches RUN.
- Hard failure: never lock.
  - After two timeouts, fail = 1, state = 4, `pll_rst` held high.
  - A `relock_req` pulse then returns state to 0 with retry_count = 0.
- Lock loss in RUN: drop `pll_locked`.
  - `core_reset_n` falls 3 cycles later; lock_loss_count = 1 (0 with the macro undefined); full sequence reruns.
- Async reset mid-STABLE: assert `reset_n` low between clock edges.
  - All outputs take their reset values before the next edge.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// Shared types and widths for the PLL reset/lock sequencer.
package pll_seq_pkg;

    localparam int STATE_W    = 3;
    localparam int LOSS_CNT_W = 16;

    typedef enum logic [STATE_W-1:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } pll_seq_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser with asynchronous active-low reset.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_p0;
    logic sync_p1;

    // Two back-to-back flops give the first stage a full cycle to resolve.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            meta_p0 <= d;
            sync_p1 <= meta_p0;
        end
    end

    assign q = sync_p1;

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer on the 74.25 MHz reference clock: pulses the PLL
// reset, filters lock, retries on timeout and releases a single core reset.
// Optional feature macro: PLL_SEQ_LOSS_COUNTER_EN enables the saturating
// lock-loss counter; without it lock_loss_count is tied to zero.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 1048576,
    parameter int MAX_RETRIES         = 7
) (
    input  logic                  clk_74a,
    input  logic                  reset_n,
    input  logic                  pll_locked,
    input  logic                  relock_req,
    output logic                  pll_rst,
    output logic                  core_reset_n,
    output logic                  ready,
    output logic                  fail,
    output logic [STATE_W-1:0]    state,
    output logic [3:0]            retry_count,
    output logic [LOSS_CNT_W-1:0] lock_loss_count
);

    // One shared counter serves all timed states, so it is sized for the largest.
    localparam int CNT_MAX_AB = (RST_PULSE_CYCLES > LOCK_STABLE_CYCLES) ?
                                RST_PULSE_CYCLES : LOCK_STABLE_CYCLES;
    localparam int CNT_MAX    = (CNT_MAX_AB > LOCK_TIMEOUT_CYCLES) ?
                                CNT_MAX_AB : LOCK_TIMEOUT_CYCLES;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

    logic           lock_s;
    pll_seq_state_t state_q, state_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic [3:0]     retry_q, retry_nxt;
`ifdef PLL_SEQ_LOSS_COUNTER_EN
    logic           loss_evt;
`endif

    sync_2ff u_lock_sync (
        .clk   (clk_74a),
        .rst_n (reset_n),
        .d     (pll_locked),
        .q     (lock_s)
    );

    // Next-state, counter and retry decisions; relock overrides everything last.
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q + CNT_W'(1);
        retry_nxt = retry_q;
`ifdef PLL_SEQ_LOSS_COUNTER_EN
        loss_evt  = 1'b0;
`endif
        case (state_q)
            RESET_PLL: begin
                if (cnt_q == RST_LAST) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_nxt = STABLE;
                    cnt_nxt   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    retry_nxt = retry_q + 4'd1;
                    cnt_nxt   = '0;
                    state_nxt = (retry_q + 4'd1 == RETRY_LIMIT) ? FAIL : RESET_PLL;
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
            end
            RUN: begin
                cnt_nxt = '0;
                if (!lock_s) begin
`ifdef PLL_SEQ_LOSS_COUNTER_EN
                    loss_evt  = 1'b1;
`endif
                    retry_nxt = '0;
                    state_nxt = RESET_PLL;
                end
            end
            FAIL: begin
                cnt_nxt = '0;
            end
            default: begin
                state_nxt = RESET_PLL;
                cnt_nxt   = '0;
            end
        endcase
        // A lock loss seen in the same cycle is still counted above.
        if (relock_req) begin
            state_nxt = RESET_PLL;
            cnt_nxt   = '0;
            retry_nxt = '0;
        end
    end

    // State register plus outputs registered from the next state, so they
    // move in the same cycle as state with no input-to-output path.
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= RESET_PLL;
            cnt_q        <= '0;
            retry_q      <= '0;
            pll_rst      <= 1'b1;
            core_reset_n <= 1'b0;
            ready        <= 1'b0;
            fail         <= 1'b0;
        end else begin
            state_q      <= state_nxt;
            cnt_q        <= cnt_nxt;
            retry_q      <= retry_nxt;
            pll_rst      <= (state_nxt == RESET_PLL) || (state_nxt == FAIL);
            core_reset_n <= (state_nxt == RUN);
            ready        <= (state_nxt == RUN);
            fail         <= (state_nxt == FAIL);
        end
    end

    assign state       = state_q;
    assign retry_count = retry_q;

`ifdef PLL_SEQ_LOSS_COUNTER_EN
    logic [LOSS_CNT_W-1:0] loss_cnt_q;

    // Saturating count of lock losses observed while running.
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            loss_cnt_q <= '0;
        end else if (loss_evt && (loss_cnt_q != '1)) begin
            loss_cnt_q <= loss_cnt_q + LOSS_CNT_W'(1);
        end
    end

    assign lock_loss_count = loss_cnt_q;
`else
    assign lock_loss_count = '0;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench for pll_lock_sequencer: stimulus tasks predict every
// output change (cycle and values) from the sequencing rules; a monitor pops
// and compares whenever the observed outputs change.
module tb_pll_lock_sequencer;

    localparam int RSTP = 4;
    localparam int STB  = 8;
    localparam int TMO  = 64;
    localparam int MAXR = 2;

    logic        clk_74a = 1'b0;
    logic        reset_n;
    logic        pll_locked;
    logic        relock_req;
    logic        pll_rst;
    logic        core_reset_n;
    logic        ready;
    logic        fail;
    logic [2:0]  state;
    logic [3:0]  retry_count;
    logic [15:0] lock_loss_count;

    pll_lock_sequencer #(
        .RST_PULSE_CYCLES    (RSTP),
        .LOCK_STABLE_CYCLES  (STB),
        .LOCK_TIMEOUT_CYCLES (TMO),
        .MAX_RETRIES         (MAXR)
    ) dut (
        .clk_74a         (clk_74a),
        .reset_n         (reset_n),
        .pll_locked      (pll_locked),
        .relock_req      (relock_req),
        .pll_rst         (pll_rst),
        .core_reset_n    (core_reset_n),
        .ready           (ready),
        .fail            (fail),
        .state           (state),
        .retry_count     (retry_count),
        .lock_loss_count (lock_loss_count)
    );

    always #5 clk_74a = ~clk_74a;

    int cyc = 0;
    always @(posedge clk_74a) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int st;
        int retry;
        int loss;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  exp_retry = 0;
    int  exp_loss = 0;
    int  t_wait = 0;
    bit  mon_en = 1'b0;
    bit  mon_primed = 1'b0;

    function automatic logic [15:0] loss_exp(input int n);
`ifdef PLL_SEQ_LOSS_COUNTER_EN
        return (n > 65535) ? 16'hFFFF : 16'(n);
`else
        return 16'(n) & 16'h0000;
`endif
    endfunction

    task automatic push(input int c, input int st);
        ev_t e;
        e.cyc = c; e.st = st; e.retry = exp_retry; e.loss = exp_loss;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d (cyc %0d)", name, act, want, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk_74a);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic pulse_relock();
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
    endtask

    task automatic check_event();
        ev_t e;
        logic [15:0] wl;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got cyc=%0d st=%0d pll_rst=%0b crn=%0b retry=%0d loss=%0d, want no change",
                     cyc, state, pll_rst, core_reset_n, retry_count, lock_loss_count);
        end else begin
            e  = exp_q.pop_front();
            wl = loss_exp(e.loss);
            if (cyc != e.cyc || state !== 3'(e.st) ||
                pll_rst !== (e.st == 0 || e.st == 4) ||
                core_reset_n !== (e.st == 3) || ready !== (e.st == 3) ||
                fail !== (e.st == 4) || retry_count !== 4'(e.retry) ||
                lock_loss_count !== wl) begin
                errors++;
                $display("FAIL event: got cyc=%0d st=%0d pll_rst=%0b crn=%0b rdy=%0b flt=%0b retry=%0d loss=%0d, want cyc=%0d st=%0d pll_rst=%0b crn=%0b rdy=%0b flt=%0b retry=%0d loss=%0d",
                         cyc, state, pll_rst, core_reset_n, ready, fail, retry_count, lock_loss_count,
                         e.cyc, e.st, (e.st == 0 || e.st == 4), (e.st == 3), (e.st == 3), (e.st == 4),
                         e.retry, wl);
            end
        end
    endtask

    // Monitor: any change of the observed output tuple must match the queue head.
    initial begin
        logic [26:0] sig, prev;
        prev = '0;
        forever begin
            @(negedge clk_74a);
            if (mon_en) begin
                sig = {state, pll_rst, core_reset_n, ready, fail, retry_count, lock_loss_count};
                if (!mon_primed) begin
                    prev = sig;
                    mon_primed = 1'b1;
                end else if (sig !== prev) begin
                    prev = sig;
                    check_event();
                end
            end
        end
    end

    task automatic chk_reset_values(input string tag);
        chk({tag, "_state"}, int'(state), 0);
        chk({tag, "_pll_rst"}, int'(pll_rst), 1);
        chk({tag, "_core_reset_n"}, int'(core_reset_n), 0);
        chk({tag, "_ready"}, int'(ready), 0);
        chk({tag, "_fail"}, int'(fail), 0);
        chk({tag, "_retry"}, int'(retry_count), 0);
        chk({tag, "_loss"}, int'(lock_loss_count), 0);
    endtask

    task automatic release_reset();
        reset_n    = 1'b1;
        exp_retry  = 0;
        exp_loss   = 0;
        mon_primed = 1'b0;
        mon_en     = 1'b1;
        push(cyc + RSTP, 1);
        t_wait = cyc + RSTP;
        wait_until(t_wait);
    endtask

    // Lock d cycles after WAIT_LOCK entry; optional glitch (high hlen, low lo).
    task automatic do_lock(input int d, input int hlen, input int lo, output int t_run);
        int t;
        t = t_wait + d;
        wait_until(t);
        pll_locked = 1'b1;
        push(t + 3, 2);
        if (hlen > 0) begin
            push(t + hlen + 3, 1);
            push(t + hlen + lo + 3, 2);
            wait_until(t + hlen);
            pll_locked = 1'b0;
            wait_until(t + hlen + lo);
            pll_locked = 1'b1;
            t = t + hlen + lo;
        end
        push(t + STB + 3, 3);
        t_run = t + STB + 3;
        wait_until(t_run);
    endtask

    task automatic do_loss(input int t_run);
        int f;
        f = t_run + $urandom_range(1, 20);
        wait_until(f);
        pll_locked = 1'b0;
        exp_loss++;
        exp_retry = 0;
        push(f + 3, 0);
        push(f + 3 + RSTP, 1);
        t_wait = f + 3 + RSTP;
        wait_until(t_wait);
    endtask

    task automatic do_relock_run(input int t_run, input bit coinc);
        int f;
        f = t_run + $urandom_range(1, 15);
        wait_until(f);
        pll_locked = 1'b0;
        if (coinc) begin
            f = f + 2;
            exp_loss++;
            wait_until(f);
        end
        exp_retry = 0;
        push(f + 1, 0);
        push(f + 1 + RSTP, 1);
        pulse_relock();
        t_wait = f + 1 + RSTP;
        wait_until(t_wait);
    endtask

    task automatic do_relock_wait();
        int c;
        c = t_wait + $urandom_range(1, 60);
        wait_until(c);
        exp_retry = 0;
        push(c + 1, 0);
        push(c + 1 + RSTP, 1);
        pulse_relock();
        t_wait = c + 1 + RSTP;
        wait_until(t_wait);
    endtask

    task automatic do_timeout();
        int c;
        exp_retry = exp_retry + 1;
        if (exp_retry == MAXR) begin
            push(t_wait + TMO, 4);
            c = t_wait + TMO + $urandom_range(1, 10);
            wait_until(c);
            chk("fail_held_fail", int'(fail), 1);
            chk("fail_held_state", int'(state), 4);
            chk("fail_held_pll_rst", int'(pll_rst), 1);
            exp_retry = 0;
            push(c + 1, 0);
            push(c + 1 + RSTP, 1);
            pulse_relock();
            t_wait = c + 1 + RSTP;
        end else begin
            push(t_wait + TMO, 0);
            push(t_wait + TMO + RSTP, 1);
            t_wait = t_wait + TMO + RSTP;
        end
        wait_until(t_wait);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: stopped at cyc %0d, want bench completion", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int tr;
        int t;
        reset_n    = 1'b1;
        pll_locked = 1'b0;
        relock_req = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk_reset_values("por");
        wait_until(3);
        release_reset();

        // Nominal lock, then lock loss in RUN.
        do_lock(10, 0, 0, tr);
        chk("nominal_ready", int'(ready), 1);
        do_loss(tr);

        // Glitchy lock: high 5, low 1, then high.
        do_lock($urandom_range(2, 30), 5, 1, tr);
        chk("glitch_retry", int'(retry_count), 0);
        do_loss(tr);

        // Timeout then success.
        do_timeout();
        chk("timeout_retry", int'(retry_count), 1);
        do_lock($urandom_range(1, 50), 0, 0, tr);
        do_loss(tr);

        // Hard failure followed by relock.
        do_timeout();
        do_timeout();
        chk("relock_retry", int'(retry_count), 0);

        // Relock in RUN, plain and coincident with lock loss.
        do_lock($urandom_range(1, 50), 0, 0, tr);
        do_relock_run(tr, 1'b0);
        do_lock($urandom_range(1, 50), 0, 0, tr);
        do_relock_run(tr, 1'b1);

        // Randomized mix of scenarios.
        for (int i = 0; i < 16; i++) begin
            case ($urandom_range(0, 5))
                0: begin do_lock($urandom_range(1, 50), 0, 0, tr); do_loss(tr); end
                1: begin
                    do_lock($urandom_range(1, 40), $urandom_range(1, 6), $urandom_range(1, 3), tr);
                    do_loss(tr);
                end
                2: do_timeout();
                3: do_relock_wait();
                4: begin do_lock($urandom_range(1, 50), 0, 0, tr); do_relock_run(tr, 1'b0); end
                default: begin do_lock($urandom_range(1, 50), 0, 0, tr); do_relock_run(tr, 1'b1); end
            endcase
        end

        // Asynchronous reset in the middle of STABLE.
        if (exp_retry == 0) do_timeout();
        t = t_wait + $urandom_range(1, 40);
        wait_until(t);
        pll_locked = 1'b1;
        push(t + 3, 2);
        wait_until(t + 5);
        chk("pre_reset_queue", exp_q.size(), 0);
        #3;
        mon_en  = 1'b0;
        reset_n = 1'b0;
        #1;
        chk_reset_values("async");
        pll_locked = 1'b0;
        wait_until(t + 9);
        release_reset();
        do_lock($urandom_range(1, 50), 0, 0, tr);
        do_loss(tr);

        wait_until(cyc + 20);
        chk("final_queue", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
